// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter between functional units and the scoreboard.
//
// Each requester owns a one-entry holding buffer. A round-robin scan starting
// at rr_q hands up to NR_WB_PORTS buffered results per cycle to the scoreboard
// write-back ports. No result is ever dropped: an FU is only ready when its
// buffer is empty or is being drained in the same cycle.
//
// Optional feature macro: WB_ARB_BYPASS_EN
//   When defined, an incoming result whose buffer is empty can be granted in
//   the same cycle (0-cycle latency); otherwise all results spend at least one
//   cycle in the buffer and there is no combinational req_* -> wb_* path.
//
// Exception bus layout (EX_W = 129): {cause[63:0], tval[63:0], valid}.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            discard all buffered and incoming results
//   req_valid_i/ready  per-FU handshake
//   req_trans_id_i, req_data_i, req_ex_i   per-FU result fields
//   trans_id_o, wbdata_o, ex_o, wb_valid_o per-port scoreboard write-back
//   pending_o          number of occupied buffers
module wb_arbiter #(
   parameter int unsigned NR_REQ        = 5,
   parameter int unsigned NR_WB_PORTS   = 2,
   parameter int unsigned TRANS_ID_BITS = 3,
   parameter int unsigned EX_W          = 129
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        flush_i,
   input  logic [NR_REQ-1:0]                           req_valid_i,
   output logic [NR_REQ-1:0]                           req_ready_o,
   input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]        req_trans_id_i,
   input  logic [NR_REQ-1:0][63:0]                     req_data_i,
   input  logic [NR_REQ-1:0][EX_W-1:0]                 req_ex_i,
   output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_o,
   output logic [NR_WB_PORTS-1:0][63:0]                wbdata_o,
   output logic [NR_WB_PORTS-1:0][EX_W-1:0]            ex_o,
   output logic [NR_WB_PORTS-1:0]                      wb_valid_o,
   output logic [$clog2(NR_REQ+1)-1:0]                 pending_o
);

   localparam int unsigned RR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
   localparam int unsigned PS_W  = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;
   localparam int unsigned CNT_W = $clog2(NR_REQ+1);

   logic [NR_REQ-1:0]                     buf_valid_q;
   logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]  buf_id_q;
   logic [NR_REQ-1:0][63:0]               buf_data_q;
   logic [NR_REQ-1:0][EX_W-1:0]           buf_ex_q;
   logic [RR_W-1:0]                       rr_q, rr_d;

   logic [NR_REQ-1:0]                     cand;
   logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]  cand_id;
   logic [NR_REQ-1:0][63:0]               cand_data;
   logic [NR_REQ-1:0][EX_W-1:0]           cand_ex;
   logic [NR_REQ-1:0]                     granted;

   // Candidate selection: the buffer always wins over the input in its slot.
   always_comb begin
      cand      = '0;
      cand_id   = '0;
      cand_data = '0;
      cand_ex   = '0;
      for (int unsigned i = 0; i < NR_REQ; i++) begin
`ifdef WB_ARB_BYPASS_EN
         cand[i]      = buf_valid_q[i] | (req_valid_i[i] & ~flush_i);
         cand_id[i]   = buf_valid_q[i] ? buf_id_q[i]   : req_trans_id_i[i];
         cand_data[i] = buf_valid_q[i] ? buf_data_q[i] : req_data_i[i];
         cand_ex[i]   = buf_valid_q[i] ? buf_ex_q[i]   : req_ex_i[i];
`else
         cand[i]      = buf_valid_q[i];
         cand_id[i]   = buf_id_q[i];
         cand_data[i] = buf_data_q[i];
         cand_ex[i]   = buf_ex_q[i];
`endif
      end
   end

   // Round-robin scan from rr_q; the first NR_WB_PORTS candidates get ports
   // 0, 1, ... in scan order. Nothing is granted during a flush.
   always_comb begin
      int unsigned     nport;
      int unsigned     pos;
      logic [RR_W-1:0] idx;
      logic [PS_W-1:0] psel;
      granted    = '0;
      wb_valid_o = '0;
      trans_id_o = '0;
      wbdata_o   = '0;
      ex_o       = '0;
      rr_d       = rr_q;
      nport      = 0;
      pos        = 0;
      idx        = '0;
      psel       = '0;
      if (!flush_i) begin
         for (int unsigned k = 0; k < NR_REQ; k++) begin
            pos = int'(rr_q) + k;
            if (pos >= NR_REQ) pos = pos - NR_REQ;
            idx = RR_W'(pos);
            if (cand[idx] && nport < NR_WB_PORTS) begin
               psel             = PS_W'(nport);
               granted[idx]     = 1'b1;
               wb_valid_o[psel] = 1'b1;
               trans_id_o[psel] = cand_id[idx];
               wbdata_o[psel]   = cand_data[idx];
               ex_o[psel]       = cand_ex[idx];
               rr_d             = (pos == NR_REQ-1) ? '0 : RR_W'(pos + 1);
               nport            = nport + 1;
            end
         end
      end
   end

   assign req_ready_o = {NR_REQ{~flush_i}} & (~buf_valid_q | granted);
   assign pending_o   = CNT_W'($countones(buf_valid_q));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_valid_q <= '0;
         buf_id_q    <= '0;
         buf_data_q  <= '0;
         buf_ex_q    <= '0;
         rr_q        <= '0;
      end else if (flush_i) begin
         buf_valid_q <= '0;
         rr_q        <= '0;
      end else begin
         rr_q <= rr_d;
         for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) begin
`ifdef WB_ARB_BYPASS_EN
               // Empty buffer and granted means the input went out directly.
               if (!buf_valid_q[i] && granted[i]) begin
                  buf_valid_q[i] <= 1'b0;
               end else begin
                  buf_valid_q[i] <= 1'b1;
                  buf_id_q[i]    <= req_trans_id_i[i];
                  buf_data_q[i]  <= req_data_i[i];
                  buf_ex_q[i]    <= req_ex_i[i];
               end
`else
               buf_valid_q[i] <= 1'b1;
               buf_id_q[i]    <= req_trans_id_i[i];
               buf_data_q[i]  <= req_data_i[i];
               buf_ex_q[i]    <= req_ex_i[i];
`endif
            end else if (granted[i]) begin
               buf_valid_q[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter between the functional units (ALU, branch unit, LSU, multiplier, CSR) and the scoreboard's write-back ports. Each FU hands a finished result (transaction ID, data, exception) to a one-entry holding buffer. A round-robin scheduler maps up to NR_WB_PORTS buffered results per cycle onto the scoreboard's `trans_id_i`/`wbdata_i`/`ex_i`/`wb_valid_i` inputs. This lets the issue stage have more producers than scoreboard write ports, and no result is ever dropped.

## Interface
- NR_REQ, default 5: number of requesting FUs; must be ≥ NR_WB_PORTS.
- NR_WB_PORTS, default 2: number of scoreboard write-back ports driven.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  pipeline flush; discards all buffered and incoming results.
- req_valid_i  in  NR_REQ  FU i presents a result.
- req_ready_o  out  NR_REQ  FU i result is accepted this cycle when valid and ready are both high.
- req_trans_id_i  in  NR_REQ×TRANS_ID_BITS  scoreboard entry of the result.
- req_data_i  in  NR_REQ×64  result data.
- req_ex_i  in  NR_REQ×exception_t  exception of the result.
- trans_id_o  out  NR_WB_PORTS×TRANS_ID_BITS  to scoreboard `trans_id_i`.
- wbdata_o  out  NR_WB_PORTS×64  to scoreboard `wbdata_i`.
- ex_o  out  NR_WB_PORTS×exception_t  to scoreboard `ex_i`.
- wb_valid_o  out  NR_WB_PORTS  to scoreboard `wb_valid_i`.
- pending_o  out  $clog2(NR_REQ+1)  number of occupied buffers.

## Operation
- **State per requester i:** buf_valid_q[i], plus the buffered trans_id, data and ex. **Global state:** rr_q, in the range 0..NR_REQ-1.
- **Candidates:** candidate[i] = buf_valid_q[i]. The bypass form is covered under Configuration.
- **Grant:**
  - Scan i = rr_q, rr_q+1, … modulo NR_REQ.
  - The first NR_WB_PORTS candidates found receive ports 0, 1, … in scan order. granted[i] is set for each of them.
  - Port p drives the granted entry's fields with wb_valid_o[p]=1.
  - Unused ports drive wb_valid_o=0 and all fields 0.
- **Pointer update:** if at least one grant is made, rr_q ← (index of last granted requester + 1) mod NR_REQ. Otherwise rr_q is unchanged.
- **Ready:** req_ready_o[i] = !flush_i && (!buf_valid_q[i] || granted[i]).
  - Ready never depends on req_valid_i[i].
- **Buffer update:**
  - Accept (valid and ready) loads the buffer and sets buf_valid_q.
  - A grant without a simultaneous accept clears buf_valid_q.
  - A grant with a simultaneous accept keeps buf_valid_q=1 and loads the new result (back-to-back throughput of 1 per FU per cycle).
- **Flush:**
  - In the flush cycle wb_valid_o=0 on all ports and req_ready_o=0.
  - On the next edge all buf_valid_q and rr_q are cleared to 0.
  - Results offered during flush are not accepted.
- **pending_o:** popcount of buf_valid_q.

## Timing
- **Reset:** buf_valid_q=0, rr_q=0, all buffered fields 0. While in reset, wb_valid_o=0, all output fields 0, pending_o=0, and req_ready_o=all ones.
- **Latency:** accept edge → wb_valid_o on the following cycle at the earliest (1 cycle).
- **Worst-case wait:** ceil(NR_REQ/NR_WB_PORTS)-1 cycles of contention, guaranteed by round-robin.
- **All buffers full, none granted:** cannot occur, since at least min(occupied, NR_WB_PORTS) grants are made every cycle.
- **Reset asserted mid-operation:** buffered results are lost and outputs go to their reset values immediately (asynchronous).
- **Duplicate trans_id across FUs:** the arbiter forwards both and does not check; avoiding this is the issue logic's responsibility.

## Configuration
- **WB_ARB_BYPASS_EN defined:**
  - candidate[i] = buf_valid_q[i] || (req_valid_i[i] && !flush_i).
  - A buffered result has priority over the input in the same slot, because the input is only considered when the buffer is empty.
  - A granted input result is driven to the port in the same cycle and is not stored (0-cycle latency).
  - An input result that is not granted is stored as normal.
- **Not defined:** latency is always exactly ≥1 cycle, and no combinational path exists from req_* to wb_*.

## Test plan
- **Reset:** assert rst_ni=0 mid-stream with 3 buffers full → wb_valid_o=0 and pending_o=0 immediately; req_ready_o=5'b11111 after release.
- **Single result:** FU2 offers trans_id=3, data=0xDEAD in cycle 0 → cycle 1: wb_valid_o=2'b01, trans_id_o[0]=3, wbdata_o[0]=0xDEAD; rr_q=3. Bypass build: the same values appear in cycle 0.
- **Contention and round-robin:** all 5 FUs offer in cycle 0 and are then idle → cycle 1 grants FU0 and FU1, cycle 2 grants FU2 and FU3, cycle 3 grants FU4; pending_o goes 5,3,1,0; each FU is seen exactly once.
- **Streaming:** FU0 and FU1 offer every cycle for 10 cycles → both see req_ready_o=1 every cycle; 20 writebacks arrive in order per FU with no gaps after the first.
- **Flush:** 4 buffers full and flush_i=1 for one cycle with new offers → wb_valid_o=0 and req_ready_o=0 in that cycle; next cycle pending_o=0 and no flushed trans_id ever appears.
- **Exception passthrough:** FU2 offers ex.valid=1 with cause 5 → ex_o on the granted port carries valid=1 and cause 5 unchanged.
